// File: rtl/freq_meter_ctrl.sv
// freq_meter_ctrl
//   Measurement sequencer for the frequency-meter datapath. Runs
//   CLEAR -> GATE -> SETTLE -> LOCK measurements back-to-back while run is
//   high, and tracks BCD-counter overflow across each gate window.
//
// Parameters
//   GATE_CYCLES : gate window length in clk cycles (>= 1)
//   GAP_CYCLES  : settle cycles between gate close and lock (>= 1)
//   CNT_W       : timer width, 2**CNT_W >= max(GATE_CYCLES, GAP_CYCLES)
//
// Ports
//   clk     in  : system clock, rising edge
//   reset   in  : synchronous active-high reset
//   run     in  : 1 = measure continuously, 0 = stop after current measurement
//   ovf_in  in  : carry out of the 4-digit BCD counter
//   cnt_clr out : one-cycle BCD counter clear
//   cnt_en  out : gate / count enable, GATE_CYCLES cycles per measurement
//   lock    out : one-cycle display-latch load pulse
//   over    out : over-range flag for the most recently latched value
//   busy    out : high whenever the sequencer is not idle
module freq_meter_ctrl #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned CNT_W       = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic ovf_in,
    output logic cnt_clr,
    output logic cnt_en,
    output logic lock,
    output logic over,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LOCK
    } state_t;

    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;
    logic             sticky;
    logic             sticky_next;

    // Next-state, timer and overflow-sticky logic. The timer is zeroed on
    // every state transition so it never wraps.
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        sticky_next = sticky;
        case (state)
            IDLE: begin
                timer_next = '0;
                if (run) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                timer_next  = '0;
                sticky_next = 1'b0;
                state_next  = GATE;
            end
            GATE: begin
                if (ovf_in) begin
                    sticky_next = 1'b1;
                end
                if (timer == GATE_LAST) begin
                    timer_next = '0;
                    state_next = SETTLE;
                end else begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (ovf_in) begin
                    sticky_next = 1'b1;
                end
                if (timer == GAP_LAST) begin
                    timer_next = '0;
                    state_next = LOCK;
                end else begin
                    timer_next = timer + CNT_W'(1);
                end
            end
            LOCK: begin
                timer_next = '0;
                state_next = run ? CLEAR : IDLE;
            end
            default: begin
                timer_next  = '0;
                sticky_next = 1'b0;
                state_next  = IDLE;
            end
        endcase
    end

    // State register. Outputs are registered by decoding the next state, so
    // each output is high during exactly the cycles its state is occupied.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            sticky  <= 1'b0;
            cnt_clr <= 1'b0;
            cnt_en  <= 1'b0;
            lock    <= 1'b0;
            busy    <= 1'b0;
            over    <= 1'b0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            sticky  <= sticky_next;
            cnt_clr <= (state_next == CLEAR);
            cnt_en  <= (state_next == GATE);
            lock    <= (state_next == LOCK);
            busy    <= (state_next != IDLE);
            // Overflow result is published on the edge that ends LOCK.
            if (state == LOCK) begin
                over <= sticky;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter_ctrl.sv
module tb_freq_meter_ctrl;

    localparam int G = 10;
    localparam int P = 2;
    localparam int LAST = G + P + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic ovf_in = 1'b0;
    logic cnt_clr, cnt_en, lock, over, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base = 0;
    bit started = 1'b0;

    freq_meter_ctrl #(
        .GATE_CYCLES(G),
        .GAP_CYCLES (P),
        .CNT_W      (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .ovf_in (ovf_in),
        .cnt_clr(cnt_clr),
        .cnt_en (cnt_en),
        .lock   (lock),
        .over   (over),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: position within a measurement (-1 = idle).
    // 0 = clear, 1..G = gate, G+1..G+P = settle, G+P+1 = lock.
    int pos = -1;
    bit m_sticky = 1'b0;
    bit m_over = 1'b0;
    bit abort_run = 1'b0;

    always @(posedge clk) begin
        int old;
        old = pos;
        if (reset) begin
            if (old >= 1 && old <= G) abort_run = 1'b1;
            pos = -1;
            m_sticky = 1'b0;
            m_over = 1'b0;
        end else if (old == -1) begin
            pos = run ? 0 : -1;
        end else if (old == LAST) begin
            m_over = m_sticky;
            pos = run ? 0 : -1;
        end else begin
            if (old == 0) m_sticky = 1'b0;
            else if (ovf_in) m_sticky = 1'b1;
            pos = old + 1;
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc - base, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc - base, act, exp);
        end
    endtask

    // Compare process: DUT vs model every cycle, plus exclusivity and
    // gate-length properties.
    int en_len = 0;
    always @(negedge clk) begin
        if (started) begin
            check("model_cnt_clr", cnt_clr, pos == 0);
            check("model_cnt_en", cnt_en, pos >= 1 && pos <= G);
            check("model_lock", lock, pos == LAST);
            check("model_busy", busy, pos != -1);
            check("model_over", over, m_over);
            check("exclusive", 1'b1, (int'(cnt_clr) + int'(cnt_en) + int'(lock)) <= 1);
            if (cnt_en === 1'b1) begin
                en_len++;
            end else if (en_len > 0) begin
                if (!abort_run) check_int("gate_len", en_len, G);
                en_len = 0;
                abort_run = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run = 1'b0;
        ovf_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = cyc;
        started = 1'b1;
    endtask

    task automatic step_to(input int c);
        while ((cyc - base) < c) @(negedge clk);
    endtask

    initial begin
        int n;

        // Continuous run timing
        do_reset();
        check("rst_cnt_clr", cnt_clr, 1'b0);
        check("rst_cnt_en", cnt_en, 1'b0);
        check("rst_lock", lock, 1'b0);
        check("rst_over", over, 1'b0);
        check("rst_busy", busy, 1'b0);
        run = 1'b1;
        step_to(1);  check("t1_clr_c1", cnt_clr, 1'b1); check("t1_busy_c1", busy, 1'b1);
        step_to(2);  check("t1_en_c2", cnt_en, 1'b1);
        step_to(11); check("t1_en_c11", cnt_en, 1'b1);
        step_to(12); check("t1_en_c12", cnt_en, 1'b0);
        step_to(14); check("t1_lock_c14", lock, 1'b1);
        step_to(15); check("t1_clr_c15", cnt_clr, 1'b1);
        n = 0;
        for (int c = 15; c <= 28; c++) begin
            step_to(c);
            if (cnt_en) n++;
        end
        check_int("t1_en_per_period", n, 10);
        check("t1_lock_c28", lock, 1'b1);
        step_to(29); check("t1_clr_c29", cnt_clr, 1'b1);

        // Overflow in GATE, then clean measurement, then reset clears over
        do_reset();
        run = 1'b1;
        step_to(6);  ovf_in = 1'b1;
        step_to(7);  ovf_in = 1'b0;
        step_to(14); check("t2_over_c14", over, 1'b0);
        step_to(15); check("t2_over_c15", over, 1'b1);
        step_to(28); check("t2_over_c28", over, 1'b1);
        step_to(29); check("t2_over_c29", over, 1'b0);
        step_to(34); ovf_in = 1'b1;
        step_to(35); ovf_in = 1'b0;
        step_to(43); check("t2_over_c43", over, 1'b1);
        step_to(44); reset = 1'b1;
        step_to(45); reset = 1'b0;
        check("t2_over_rst", over, 1'b0);
        check("t2_busy_rst", busy, 1'b0);

        // Overflow ignored in IDLE/CLEAR/LOCK, honoured in SETTLE
        do_reset();
        run = 1'b1;
        ovf_in = 1'b1;
        step_to(2);  ovf_in = 1'b0;
        step_to(15); check("t3_over_c15", over, 1'b0);
        step_to(27); ovf_in = 1'b1;
        step_to(28); ovf_in = 1'b0;
        step_to(29); check("t3_over_c29", over, 1'b1);
        step_to(42); ovf_in = 1'b1;
        step_to(44); ovf_in = 1'b0;
        step_to(43); check("t3_over_c43", over, 1'b0);
        step_to(57); check("t3_over_c57", over, 1'b0);

        // run dropped mid-gate
        do_reset();
        run = 1'b1;
        step_to(5);  run = 1'b0;
        step_to(14); check("t4_lock_c14", lock, 1'b1);
        step_to(15); check("t4_busy_c15", busy, 1'b0); check("t4_clr_c15", cnt_clr, 1'b0);
        step_to(20); check("t4_busy_c20", busy, 1'b0); check("t4_en_c20", cnt_en, 1'b0);

        // reset during SETTLE
        do_reset();
        run = 1'b1;
        step_to(12); reset = 1'b1;
        step_to(13); reset = 1'b0;
        check("t5_clr_c13", cnt_clr, 1'b0);
        check("t5_en_c13", cnt_en, 1'b0);
        check("t5_lock_c13", lock, 1'b0);
        check("t5_busy_c13", busy, 1'b0);
        check("t5_over_c13", over, 1'b0);
        step_to(14); check("t5_lock_c14", lock, 1'b0); check("t5_clr_c14", cnt_clr, 1'b1);

        // Randomized traffic, checked by the model and properties
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 29) == 0) run = ~run;
            ovf_in = ($urandom_range(0, 24) == 0);
        end
        reset = 1'b0;
        run = 1'b0;
        ovf_in = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
